// File: rtl/muldiv_alu_if.sv
// Handshake and operand/result bundle for the muldiv_alu execute unit.
// The pipeline drives the master side and the execute unit implements the slave side.
interface muldiv_alu_if #(
   parameter int XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [4:0]      op;
   logic [XLEN-1:0] a_in;
   logic [XLEN-1:0] b_in;
   logic            kill;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;

   modport master (
      output in_valid, op, a_in, b_in, kill, out_ready,
      input  in_ready, out_valid, result
   );

   modport slave (
      input  in_valid, op, a_in, b_in, kill, out_ready,
      output in_ready, out_valid, result
   );
endinterface

// File: rtl/muldiv_alu.sv
// RV32I base ALU plus radix-2 iterative RV32M multiply/divide behind a valid/ready handshake.
// Define MULDIV_FAST_MUL_EN to replace the shift-add multiplier with a one-cycle product.
module muldiv_alu #(
   parameter int XLEN = 32
) (
   input logic         clk,
   input logic         rst_n,
   muldiv_alu_if.slave bus
);
   localparam int SHW = $clog2(XLEN);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   state_e            state_r;
   state_e            state_nxt_s;
   logic [SHW-1:0]    cnt_r;
   logic [2:0]        fn_r;
   logic [XLEN-1:0]   opnd_r;
   logic [2*XLEN-1:0] acc_r;
   logic              neg_r;
   logic              neg_rem_r;
   logic [XLEN-1:0]   result_r;
   logic              out_valid_r;

   logic              in_ready_s;
   logic              accept_s;
   logic              last_s;
   logic              a_sgn_s;
   logic              b_sgn_s;
   logic              a_neg_s;
   logic              b_neg_s;
   logic [XLEN-1:0]   a_mag_s;
   logic [XLEN-1:0]   b_mag_s;
   logic              div_zero_s;
   logic              div_ovf_s;
   logic              special_s;
   logic [XLEN-1:0]   special_res_s;
   logic [XLEN:0]     div_shift_s;
   logic              div_ge_s;
   logic [XLEN-1:0]   div_sub_s;
   logic [2*XLEN-1:0] acc_nxt_s;
   logic [2*XLEN-1:0] prod_s;
   logic [XLEN-1:0]   quo_s;
   logic [XLEN-1:0]   rem_s;
   logic [XLEN-1:0]   final_s;
`ifndef MULDIV_FAST_MUL_EN
   logic [XLEN:0]     mul_sum_s;
`endif

   // Single-cycle base integer operations; unknown codes fall back to ADD.
   function automatic logic [XLEN-1:0] alu_base(
      input logic [3:0]      code,
      input logic [XLEN-1:0] a,
      input logic [XLEN-1:0] b
   );
      logic [SHW-1:0] sh;
      sh = b[SHW-1:0];
      case (code)
         4'b1000: alu_base = a - b;
         4'b0111: alu_base = a & b;
         4'b0110: alu_base = a | b;
         4'b0100: alu_base = a ^ b;
         4'b0001: alu_base = a << sh;
         4'b0101: alu_base = a >> sh;
         4'b1101: alu_base = $signed(a) >>> sh;
         4'b0010: alu_base = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
         4'b0011: alu_base = {{(XLEN-1){1'b0}}, (a < b)};
         default: alu_base = a + b;
      endcase
   endfunction

   // Operand signedness, magnitudes and division special cases decoded at accept.
   always_comb begin
      a_sgn_s = 1'b0;
      b_sgn_s = 1'b0;
      if (bus.op[2]) begin
         a_sgn_s = ~bus.op[0];
         b_sgn_s = ~bus.op[0];
      end else begin
         a_sgn_s = (bus.op[2:0] == 3'b001) || (bus.op[2:0] == 3'b010);
         b_sgn_s = (bus.op[2:0] == 3'b001);
      end
      a_neg_s    = a_sgn_s & bus.a_in[XLEN-1];
      b_neg_s    = b_sgn_s & bus.b_in[XLEN-1];
      a_mag_s    = a_neg_s ? -bus.a_in : bus.a_in;
      b_mag_s    = b_neg_s ? -bus.b_in : bus.b_in;
      div_zero_s = (bus.b_in == {XLEN{1'b0}});
      div_ovf_s  = a_sgn_s && (bus.a_in == {1'b1, {(XLEN-1){1'b0}}}) && (bus.b_in == {XLEN{1'b1}});
      special_s  = bus.op[4] & bus.op[2] & (div_zero_s | div_ovf_s);
      if (div_zero_s) begin
         special_res_s = bus.op[1] ? bus.a_in : {XLEN{1'b1}};
      end else begin
         special_res_s = bus.op[1] ? {XLEN{1'b0}} : bus.a_in;
      end
   end

   // One radix-2 step: restoring divide (hi=remainder, lo=quotient) or shift-add multiply.
   always_comb begin
      div_shift_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-1]};
      div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
      div_sub_s   = div_shift_s[XLEN-1:0] - opnd_r;
`ifndef MULDIV_FAST_MUL_EN
      mul_sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
`endif
      if (fn_r[2]) begin
         if (div_ge_s) begin
            acc_nxt_s = {div_sub_s, acc_r[XLEN-2:0], 1'b1};
         end else begin
            acc_nxt_s = {div_shift_s[XLEN-1:0], acc_r[XLEN-2:0], 1'b0};
         end
      end else begin
`ifdef MULDIV_FAST_MUL_EN
         acc_nxt_s = {{XLEN{1'b0}}, opnd_r} * {{XLEN{1'b0}}, acc_r[XLEN-1:0]};
`else
         acc_nxt_s = {mul_sum_s, acc_r[XLEN-1:1]};
`endif
      end
   end

   // Sign correction and result selection applied on the final iteration.
   always_comb begin
      prod_s = neg_r ? -acc_nxt_s : acc_nxt_s;
      quo_s  = neg_r ? -acc_nxt_s[XLEN-1:0] : acc_nxt_s[XLEN-1:0];
      rem_s  = neg_rem_r ? -acc_nxt_s[2*XLEN-1:XLEN] : acc_nxt_s[2*XLEN-1:XLEN];
      if (fn_r[2]) begin
         final_s = fn_r[1] ? rem_s : quo_s;
      end else if (fn_r == 3'b000) begin
         final_s = prod_s[XLEN-1:0];
      end else begin
         final_s = prod_s[2*XLEN-1:XLEN];
      end
`ifdef MULDIV_FAST_MUL_EN
      last_s = ~fn_r[2] | (cnt_r == SHW'(XLEN-1));
`else
      last_s = (cnt_r == SHW'(XLEN-1));
`endif
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; kill outranks completion and out_ready.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.in_valid && !bus.kill) begin
               state_nxt_s = (!bus.op[4] || special_s) ? ST_DONE : ST_BUSY;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_BUSY: begin
            if (bus.kill) begin
               state_nxt_s = ST_IDLE;
            end else if (last_s) begin
               state_nxt_s = ST_DONE;
            end else begin
               state_nxt_s = ST_BUSY;
            end
         end
         ST_DONE: begin
            if (bus.kill || bus.out_ready) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_DONE;
            end
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // State-decoded outputs.
   always_comb begin
      case (state_r)
         ST_IDLE: in_ready_s = 1'b1;
         ST_BUSY: in_ready_s = 1'b0;
         ST_DONE: in_ready_s = 1'b0;
         default: in_ready_s = 1'b0;
      endcase
      accept_s = in_ready_s & bus.in_valid & ~bus.kill;
   end

   // Datapath: operand capture at accept, iteration in BUSY, registered result/out_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r       <= {SHW{1'b0}};
         fn_r        <= 3'b000;
         opnd_r      <= {XLEN{1'b0}};
         acc_r       <= {(2*XLEN){1'b0}};
         neg_r       <= 1'b0;
         neg_rem_r   <= 1'b0;
         result_r    <= {XLEN{1'b0}};
         out_valid_r <= 1'b0;
      end else begin
         out_valid_r <= (state_nxt_s == ST_DONE);
         cnt_r       <= ((state_r == ST_BUSY) && (state_nxt_s == ST_BUSY)) ? cnt_r + 1'b1 : {SHW{1'b0}};
         if (accept_s) begin
            fn_r      <= bus.op[2:0];
            neg_r     <= a_neg_s ^ b_neg_s;
            neg_rem_r <= a_neg_s;
            if (bus.op[2]) begin
               opnd_r <= b_mag_s;
               acc_r  <= {{XLEN{1'b0}}, a_mag_s};
            end else begin
               opnd_r <= a_mag_s;
               acc_r  <= {{XLEN{1'b0}}, b_mag_s};
            end
            if (!bus.op[4]) begin
               result_r <= alu_base(bus.op[3:0], bus.a_in, bus.b_in);
            end else if (special_s) begin
               result_r <= special_res_s;
            end else begin
               result_r <= result_r;
            end
         end else if ((state_r == ST_BUSY) && !bus.kill) begin
            acc_r <= acc_nxt_s;
            if (last_s) begin
               result_r <= final_s;
            end else begin
               result_r <= result_r;
            end
         end else begin
            acc_r <= acc_r;
         end
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_r;
   assign bus.result    = result_r;

endmodule

// File: tb/tb_muldiv_alu.sv
// Directed self-checking bench for muldiv_alu: base ops, RV32M ops, special cases,
// backpressure, kill and asynchronous reset in the middle of an iterative operation.
module tb_muldiv_alu;
   localparam int XLEN = 32;
`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = 33;
`endif
   localparam int DIV_LAT = 33;

   localparam logic [4:0] OP_ADD    = 5'b00000;
   localparam logic [4:0] OP_SUB    = 5'b01000;
   localparam logic [4:0] OP_AND    = 5'b00111;
   localparam logic [4:0] OP_OR     = 5'b00110;
   localparam logic [4:0] OP_XOR    = 5'b00100;
   localparam logic [4:0] OP_SLL    = 5'b00001;
   localparam logic [4:0] OP_SRL    = 5'b00101;
   localparam logic [4:0] OP_SRA    = 5'b01101;
   localparam logic [4:0] OP_SLT    = 5'b00010;
   localparam logic [4:0] OP_SLTU   = 5'b00011;
   localparam logic [4:0] OP_BAD    = 5'b01111;
   localparam logic [4:0] OP_MUL    = 5'b10000;
   localparam logic [4:0] OP_MULH   = 5'b10001;
   localparam logic [4:0] OP_MULHSU = 5'b10010;
   localparam logic [4:0] OP_MULHU  = 5'b11011;
   localparam logic [4:0] OP_DIV    = 5'b10100;
   localparam logic [4:0] OP_DIVU   = 5'b10101;
   localparam logic [4:0] OP_REM    = 5'b10110;
   localparam logic [4:0] OP_REMU   = 5'b10111;

   logic clk = 1'b0;
   logic rst_n;
   int   checks_cnt = 0;
   int   errors_cnt = 0;

   always #5 clk = ~clk;

   muldiv_alu_if #(.XLEN(XLEN)) bus ();

   muldiv_alu #(.XLEN(XLEN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks_cnt++;
      assert (obs === exp) else begin
         errors_cnt++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Issue one op from a negedge, measure latency in edges, check result, then consume it.
   task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp, input int lat_exp);
      int lat;
      check({tag, "/in_ready"}, bus.in_ready, 64'd1);
      bus.in_valid = 1'b1;
      bus.op       = op;
      bus.a_in     = a;
      bus.b_in     = b;
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 1;
      while (bus.out_valid !== 1'b1 && lat < 100) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "/latency"}, 64'(lat), 64'(lat_exp));
      check({tag, "/result"}, bus.result, exp);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check({tag, "/idle_after"}, {bus.in_ready, bus.out_valid}, 64'd2);
   endtask

   initial begin
      int seen;
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.op        = 5'b00000;
      bus.a_in      = 32'h0;
      bus.b_in      = 32'h0;
      bus.kill      = 1'b0;
      bus.out_ready = 1'b0;
      @(negedge clk);
      check("rst/out_valid", bus.out_valid, 64'd0);
      check("rst/result", bus.result, 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst/in_ready", bus.in_ready, 64'd1);

      run_op("add_ovf", OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1);
      run_op("sra",     OP_SRA,  32'h8000_0000, 32'h0000_0024, 32'hF800_0000, 1);
      run_op("sub",     OP_SUB,  32'h0000_0005, 32'h0000_0007, 32'hFFFF_FFFE, 1);
      run_op("and",     OP_AND,  32'hF0F0_1234, 32'h0FF0_FF00, 32'h00F0_1200, 1);
      run_op("or",      OP_OR,   32'hF000_0001, 32'h0F00_0010, 32'hFF00_0011, 1);
      run_op("xor",     OP_XOR,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1);
      run_op("sll",     OP_SLL,  32'h0000_0001, 32'h0000_003F, 32'h8000_0000, 1);
      run_op("srl",     OP_SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1);
      run_op("slt",     OP_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1);
      run_op("sltu",    OP_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1);
      run_op("bad_add", OP_BAD,  32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1);

      run_op("mul",    OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, MUL_LAT);
      run_op("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT);
      run_op("mulh",   OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT);
      run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT);
      run_op("mulh2",  OP_MULH,   32'h8000_0000, 32'h0000_0003, 32'hFFFF_FFFE, MUL_LAT);

      run_op("div",    OP_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, DIV_LAT);
      run_op("rem",    OP_REM,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, DIV_LAT);
      run_op("rem_n",  OP_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, DIV_LAT);
      run_op("divu",   OP_DIVU, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, DIV_LAT);
      run_op("remu",   OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, DIV_LAT);

      run_op("divu_z", OP_DIVU, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1);
      run_op("remu_z", OP_REMU, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1);
      run_op("div_z",  OP_DIV,  32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1);
      run_op("div_ov", OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("rem_ov", OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);

      // Backpressure: hold out_ready low for 5 cycles in DONE.
      bus.in_valid = 1'b1;
      bus.op       = OP_ADD;
      bus.a_in     = 32'h0000_0003;
      bus.b_in     = 32'h0000_0004;
      @(negedge clk);
      bus.in_valid = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check("bp/result", bus.result, 64'd7);
         check("bp/in_ready", bus.in_ready, 64'd0);
         check("bp/out_valid", bus.out_valid, 64'd1);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      check("bp/release", {bus.in_ready, bus.out_valid}, 64'd2);

      // kill together with in_valid in IDLE blocks the accept.
      bus.in_valid = 1'b1;
      bus.kill     = 1'b1;
      bus.op       = OP_ADD;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.kill     = 1'b0;
      check("kill_idle", {bus.in_ready, bus.out_valid}, 64'd2);

      // kill at BUSY cycle 10 of a DIV.
      bus.in_valid = 1'b1;
      bus.op       = OP_DIV;
      bus.a_in     = 32'h0000_0064;
      bus.b_in     = 32'h0000_0007;
      @(negedge clk);
      bus.in_valid = 1'b0;
      check("kill/busy", bus.in_ready, 64'd0);
      repeat (10) @(negedge clk);
      bus.kill = 1'b1;
      @(negedge clk);
      bus.kill = 1'b0;
      check("kill/idle", {bus.in_ready, bus.out_valid}, 64'd2);
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (bus.out_valid === 1'b1) seen++;
         @(negedge clk);
      end
      check("kill/no_valid", 64'(seen), 64'd0);
      check("kill/result_held", bus.result, 64'd7);

      // Asynchronous reset mid-BUSY, then a clean operation.
      bus.in_valid = 1'b1;
      bus.op       = OP_MULHU;
      bus.a_in     = 32'h1234_5678;
      bus.b_in     = 32'h9ABC_DEF0;
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_busy/out_valid", bus.out_valid, 64'd0);
      check("rst_busy/result", bus.result, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_op("post_rst_divu", OP_DIVU, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E, DIV_LAT);
      run_op("post_rst_mulhu", OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, MUL_LAT);

      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end
endmodule

// File: doc/muldiv_alu.md
# muldiv_alu

Multi-cycle, parametrised execute unit for the RV32I core that extends the single-cycle integer ALU with the RV32M multiply/divide operations. Base integer ops complete in one cycle. MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU run on an iterative radix-2 datapath. A valid/ready handshake on both sides lets the pipeline stall on long operations, and a synchronous kill aborts an in-flight operation on a flush.

## Interface
Parameters:
- XLEN, 32, operand/result width; power of two, 8..64
- SHW, $clog2(XLEN), shift-amount width (derived; not overridden)

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation offered
- in_ready  out  1  unit can accept; high only in IDLE
- op  in  5  op[4]=0: base ALU op in op[3:0]; op[4]=1: M-ext op, op[2:0]=funct3
- a_in  in  XLEN  operand A (rs1)
- b_in  in  XLEN  operand B (rs2/imm)
- kill  in  1  synchronous abort of the current operation
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  XLEN  result, stable while out_valid=1

## Operation
- Base encodings (op[4]=0):
  - 0000 ADD; 1000 SUB; 0111 AND; 0110 OR; 0100 XOR
  - 0001 SLL; 0101 SRL; 1101 SRA, shift by b_in[SHW-1:0]
  - 0010 SLT signed; 0011 SLTU; result 1 or 0
  - Any other code → ADD.
- M encodings (op[4]=1, funct3):
  - 000 MUL, low XLEN of product
  - 001 MULH s×s, high; 010 MULHSU s×u, high; 011 MULHU u×u, high
  - 100 DIV; 101 DIVU; 110 REM; 111 REMU
- op[3] is ignored when op[4]=1.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: in_ready=1. On in_valid, latch operands and op.
    - Base op or division special case → DONE.
    - Any other M op → BUSY.
  - BUSY: iteration counter counts 0..XLEN-1. At count XLEN-1 → DONE.
    - Multiply: shift-add on operand magnitudes, 2·XLEN-bit accumulator.
    - Divide: restoring division on magnitudes.
    - Sign correction is applied when the final iteration writes result.
  - DONE: out_valid=1. On out_ready → IDLE. No new accept in DONE.
- Division special cases, resolved at accept with no iteration:
  - Divide by zero: DIV/DIVU → all ones; REM/REMU → a_in.
  - Signed overflow (a_in = 100…0, b_in = all ones): DIV → a_in; REM → 0.
- Sign rules:
  - Quotient is negative iff the operand signs differ.
  - Remainder takes the dividend's sign.
  - MULHSU treats b_in as unsigned.
- kill:
  - In BUSY or DONE: next state is IDLE, out_valid=0, result discarded.
  - In IDLE: no effect. kill with in_valid in IDLE blocks the accept.
  - kill takes priority over completion and over out_ready.
- rst_n low, at any time including mid-BUSY:
  - State → IDLE, counter → 0.
  - out_valid=0 and result=0 immediately.
  - in_ready=1 from reset deassertion.

## Timing
- Accept is in_valid & in_ready sampled at edge k.
- Base op or division special case: out_valid high after edge k+1 (latency 1).
- Iterative M op: BUSY for exactly XLEN cycles; out_valid high after edge k+XLEN+1 (latency 33 at XLEN=32).
- Handshake completes at the first edge where out_valid & out_ready. in_ready rises after that edge.
- Peak throughput is one base op per 2 cycles.
- result and out_valid are registered outputs. in_ready is decoded from state only, with no combinational path from inputs.
- result holds its last value outside DONE. Do not depend on it when out_valid=0.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - Multiplies use a single-cycle XLEN×XLEN combinational product computed in BUSY.
  - BUSY lasts 1 cycle; multiply latency is 2.
  - Divides are unchanged.
- Not defined: iterative shift-add multiply, latency XLEN+1. Minimum area.

## Test plan
- ADD a=0x7FFFFFFF, b=1 → result 0x80000000. out_valid one cycle after accept. SRA a=0x80000000, b=0x24 → 0xF8000000 (shift 4).
- a=b=0xFFFFFFFF:
  - MUL → 0x00000001; MULHU → 0xFFFFFFFE; MULH → 0x00000000; MULHSU → 0xFFFFFFFF.
  - Each has latency 33, or 2 with MULDIV_FAST_MUL_EN.
- DIV 7/−2 → 0xFFFFFFFD; REM → 0x00000001; DIVU 0x64/7 → 0x0E. Each has latency 33.
- Special cases, each with latency 1:
  - DIVU 5/0 → 0xFFFFFFFF; REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0.
- Backpressure: out_ready held low 5 cycles in DONE.
  - result stays stable and in_ready stays 0 throughout.
  - Raising out_ready returns the unit to IDLE one edge later.
- Abort paths:
  - kill at BUSY cycle 10 of a DIV → IDLE next edge; out_valid never asserts.
  - rst_n low mid-BUSY → out_valid=0 and result=0 immediately; the next op after release runs correctly.
